// File: rtl/xor_accum_pipe_pkg.sv
// Package for the XOR/accumulate pipeline.
// Holds the per-beat operation encoding shared by the interface and the top.
package xor_accum_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_XOR    = 2'd0,
    OP_XNOR   = 2'd1,
    OP_ACCUM  = 2'd2,
    OP_PASS_A = 2'd3
  } op_e;

endpackage

// File: rtl/xor_accum_pipe_if.sv
// Operand/result bus of the XOR/accumulate pipeline.
//  clear      producer -> block  synchronous accumulator clear
//  in_valid   producer -> block  operand beat valid
//  in_ready   block -> producer  beat accepted this cycle when both high
//  a, b       producer -> block  operands
//  mode       producer -> block  per-beat operation
//  out_valid  block -> consumer  result valid
//  out_ready  consumer -> block  consumer takes result
//  out_data   block -> consumer  result
//  out_parity block -> consumer  XOR-reduce of out_data
//  acc_data   block -> consumer  registered accumulator value
interface xor_accum_pipe_if
  import xor_accum_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_e              mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_parity;
  logic [WIDTH-1:0] acc_data;

  modport master (
    output clear, in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, out_data, out_parity, acc_data
  );

  modport slave (
    input  clear, in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, out_data, out_parity, acc_data
  );

endinterface

// File: rtl/xor_accum_pipe_stage.sv
// One valid/data register of the pipeline with its enable logic.
//  clk, reset_n  clock, async active-low reset
//  in_v, in_d    beat offered by the previous stage
//  nxt_rdy       next stage (or consumer) takes this stage's beat
//  out_v, out_d  registered beat
//  rdy           this stage loads a new beat this cycle
module pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_v,
  input  logic [WIDTH-1:0] in_d,
  input  logic             nxt_rdy,
  output logic             out_v,
  output logic [WIDTH-1:0] out_d,
  output logic             rdy
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  // Empty or draining this cycle: bubbles are overwritten, never held.
  assign rdy = !v_q || nxt_rdy;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (rdy) begin
      v_d = in_v;
      // Data only moves with a real beat so it holds its last value otherwise.
      if (in_v) d_d = in_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign out_v = v_q;
  assign out_d = d_q;

endmodule

// File: rtl/xor_accum_pipe.sv
// WIDTH-bit XOR / XNOR / running-XOR accumulate / pass-A unit behind a
// STAGES-deep valid/ready pipeline with backpressure.
//  clk      rising-edge clock
//  reset_n  asynchronous active-low reset
//  bus      operand/result bus (slave side), see xor_accum_pipe_if
module xor_accum_pipe
  import xor_accum_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  xor_accum_pipe_if.slave     bus
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] res_d;
  logic             accept;

  logic             s1_v, s1_rdy, s1_nxt_rdy;
  logic [WIDTH-1:0] s1_d;
  logic             last_v;
  logic [WIDTH-1:0] last_d;

  always_comb begin
    accept   = bus.in_valid && s1_rdy;
    // Clear takes effect before an ACCUM beat in the same cycle.
    acc_base = bus.clear ? '0 : acc_q;
    acc_d    = acc_base;
    res_d    = '0;
    case (bus.mode)
      OP_XOR:    res_d = bus.a ^ bus.b;
      OP_XNOR:   res_d = ~(bus.a ^ bus.b);
      OP_ACCUM:  res_d = acc_base ^ bus.a ^ bus.b;
      OP_PASS_A: res_d = bus.a;
      default:   res_d = bus.a;
    endcase
    if (accept && bus.mode == OP_ACCUM) acc_d = acc_base ^ bus.a ^ bus.b;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

  pipe_stage #(.WIDTH(WIDTH)) u_stage1 (
    .clk     (clk),
    .reset_n (reset_n),
    .in_v    (bus.in_valid),
    .in_d    (res_d),
    .nxt_rdy (s1_nxt_rdy),
    .out_v   (s1_v),
    .out_d   (s1_d),
    .rdy     (s1_rdy)
  );

  // Each later stage keeps its own scalar handshake nets so the ready chain
  // is a plain combinational path from out_ready back to in_ready.
  if (STAGES == 1) begin : g_single
    assign s1_nxt_rdy = bus.out_ready;
    assign last_v     = s1_v;
    assign last_d     = s1_d;
  end else begin : g_chain
    for (genvar i = 2; i <= STAGES; i++) begin : g_stage
      logic             prv_v, nxt_rdy, v, rdy;
      logic [WIDTH-1:0] prv_d, d;

      if (i == 2) begin : g_head
        assign prv_v = s1_v;
        assign prv_d = s1_d;
      end else begin : g_body
        assign prv_v = g_stage[i-1].v;
        assign prv_d = g_stage[i-1].d;
      end

      if (i == STAGES) begin : g_tail
        assign nxt_rdy = bus.out_ready;
      end else begin : g_link
        assign nxt_rdy = g_stage[i+1].rdy;
      end

      pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .in_v    (prv_v),
        .in_d    (prv_d),
        .nxt_rdy (nxt_rdy),
        .out_v   (v),
        .out_d   (d),
        .rdy     (rdy)
      );
    end

    assign s1_nxt_rdy = g_stage[2].rdy;
    assign last_v     = g_stage[STAGES].v;
    assign last_d     = g_stage[STAGES].d;
  end

  assign bus.in_ready   = s1_rdy;
  assign bus.out_valid  = last_v;
  assign bus.out_data   = last_d;
  assign bus.out_parity = ^last_d;
  assign bus.acc_data   = acc_q;

endmodule

// File: tb/tb_xor_accum_pipe.sv
// Directed bench for xor_accum_pipe with a result scoreboard.
module tb_xor_accum_pipe;
  import xor_accum_pkg::*;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  typedef logic [WIDTH-1:0] dw_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  xor_accum_pipe_if #(.WIDTH(WIDTH)) bus ();

  xor_accum_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int  total = 0;
  int  bad   = 0;
  dw_t sb[$];
  dw_t acc_m;

  task automatic check(input string tag, input dw_t obs, input dw_t exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic dw_t model(input op_e m, input dw_t a, input dw_t b, input logic clr);
    dw_t base;
    base = clr ? '0 : acc_m;
    case (m)
      OP_XOR:   return a ^ b;
      OP_XNOR:  return ~(a ^ b);
      OP_ACCUM: return base ^ a ^ b;
      default:  return a;
    endcase
  endfunction

  // Offers one beat, waits (bounded) for acceptance, returns at posedge+1.
  task automatic send(input op_e m, input dw_t a, input dw_t b, input logic clr);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.a        = a;
    bus.b        = b;
    bus.clear    = clr;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (!ok) begin
      check("accept_timeout", dw_t'(bus.in_ready), dw_t'(1));
    end else begin
      sb.push_back(model(m, a, b, clr));
      if (clr) acc_m = '0;
      if (m == OP_ACCUM) acc_m = acc_m ^ a ^ b;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.out_valid) break;
    end
    check("drain_sb_empty", dw_t'(sb.size()), dw_t'(0));
    check("drain_out_valid", dw_t'(bus.out_valid), dw_t'(0));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("extra_beat", dw_t'(bus.out_valid), dw_t'(0));
      end else begin
        dw_t e;
        e = sb.pop_front();
        check("out_data", bus.out_data, e);
        check("out_parity", dw_t'(bus.out_parity), dw_t'(^e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    dw_t hold;
    reset_n       = 1'b0;
    bus.out_ready = 1'b1;
    acc_m         = '0;
    repeat (3) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.clear    = 1'($urandom_range(0, 1));
      bus.a        = dw_t'($urandom);
      bus.b        = dw_t'($urandom);
      bus.mode     = op_e'($urandom_range(0, 3));
      @(negedge clk);
      check("rst_out_valid", dw_t'(bus.out_valid), dw_t'(0));
      check("rst_acc_data", bus.acc_data, dw_t'(0));
      check("rst_out_data", bus.out_data, dw_t'(0));
    end
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", dw_t'(bus.in_ready), dw_t'(1));
    @(posedge clk);
    #1;

    // XOR with latency check
    send(OP_XOR, 8'hF0, 8'h3C, 1'b0);
    check("lat_not_early", dw_t'(bus.out_valid), dw_t'(0));
    @(posedge clk);
    #1;
    check("lat_valid", dw_t'(bus.out_valid), dw_t'(1));
    check("xor_data", bus.out_data, 8'hCC);
    check("xor_parity", dw_t'(bus.out_parity), dw_t'(0));
    drain();

    // Accumulate stream, then clear together with an ACCUM beat
    send(OP_ACCUM, 8'h01, 8'h02, 1'b0);
    send(OP_ACCUM, 8'h04, 8'h00, 1'b0);
    send(OP_ACCUM, 8'hFF, 8'h00, 1'b0);
    check("acc_after_stream", bus.acc_data, 8'hF8);
    drain();
    send(OP_ACCUM, 8'h11, 8'h22, 1'b1);
    check("acc_clear_accum", bus.acc_data, 8'h33);
    drain();

    // Mode mix leaves the accumulator alone
    send(OP_XNOR, 8'h00, 8'h00, 1'b0);
    send(OP_PASS_A, 8'h07, 8'h5A, 1'b0);
    check("acc_mode_mix", bus.acc_data, 8'h33);
    drain();

    // Clear with a non-ACCUM beat: result untouched, acc zeroed
    send(OP_XOR, 8'h05, 8'h03, 1'b1);
    check("acc_clear_xor", bus.acc_data, 8'h00);
    drain();

    // Backpressure: 6-beat burst with out_ready low for 5 cycles
    bus.out_ready = 1'b0;
    send(OP_XOR, 8'h10, 8'h03, 1'b0);
    send(OP_XOR, 8'h21, 8'h03, 1'b0);
    check("bp_in_ready_low", dw_t'(bus.in_ready), dw_t'(0));
    check("bp_out_valid", dw_t'(bus.out_valid), dw_t'(1));
    hold = bus.out_data;
    check("bp_head_data", hold, sb[0]);
    // Rejected ACCUM beat must not touch the accumulator
    bus.in_valid = 1'b1;
    bus.mode     = OP_ACCUM;
    bus.a        = 8'hAA;
    bus.b        = 8'h55;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_hold_data", bus.out_data, hold);
      check("bp_hold_ready", dw_t'(bus.in_ready), dw_t'(0));
      check("bp_acc_kept", bus.acc_data, acc_m);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    send(OP_XOR, 8'h32, 8'h03, 1'b0);
    send(OP_XOR, 8'h43, 8'h03, 1'b0);
    send(OP_XOR, 8'h54, 8'h03, 1'b0);
    send(OP_XOR, 8'h65, 8'h03, 1'b0);
    drain();
    check("bp_acc_final", bus.acc_data, 8'h00);

    // Reset with two beats in flight
    bus.out_ready = 1'b0;
    send(OP_ACCUM, 8'h12, 8'h34, 1'b0);
    send(OP_ACCUM, 8'h56, 8'h00, 1'b0);
    check("mid_acc_before", bus.acc_data, 8'h70);
    #2;
    reset_n = 1'b0;
    sb.delete();
    acc_m = '0;
    #1;
    check("mid_out_valid", dw_t'(bus.out_valid), dw_t'(0));
    check("mid_acc_data", bus.acc_data, dw_t'(0));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_quiet", dw_t'(bus.out_valid), dw_t'(0));
    end
    @(posedge clk);
    #1;
    send(OP_XOR, 8'hAA, 8'h0F, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
